// File: rtl/noc_stream_pkg.sv
// Shared types for tile stream paths: beat layout, arbiter FSM states
// and a helper that sizes requester index fields.
package noc_stream_pkg;

    localparam int NOC_DATA_W = 32;
    localparam int NOC_KEEP_W = NOC_DATA_W / 8;

    // One AXI-Stream beat at the default tile data width.
    typedef struct packed {
        logic [NOC_DATA_W-1:0] data;
        logic [NOC_KEEP_W-1:0] keep;
        logic                  last;
    } noc_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int noc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Stream bundle between N_REQ tile sources and the tile NoC output.
// slave: arbiter side; master: sources/sink side.
interface noc_out_arbiter_if
    import noc_stream_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = NOC_DATA_W
);

    logic [N_REQ-1:0]          req_TVALID;
    logic [N_REQ*DATA_W-1:0]   req_TDATA;
    logic [N_REQ*DATA_W/8-1:0] req_TKEEP;
    logic [N_REQ-1:0]          req_TLAST;
    logic [N_REQ-1:0]          req_TREADY;

    logic                      stream_out_TREADY;
    logic                      stream_out_TVALID;
    logic [DATA_W-1:0]         stream_out_TDATA;
    logic [DATA_W/8-1:0]       stream_out_TKEEP;
    logic                      stream_out_TLAST;

    modport slave (
        input  req_TVALID, req_TDATA, req_TKEEP, req_TLAST,
        input  stream_out_TREADY,
        output req_TREADY,
        output stream_out_TVALID, stream_out_TDATA,
        output stream_out_TKEEP, stream_out_TLAST
    );

    modport master (
        output req_TVALID, req_TDATA, req_TKEEP, req_TLAST,
        output stream_out_TREADY,
        input  req_TREADY,
        input  stream_out_TVALID, stream_out_TDATA,
        input  stream_out_TKEEP, stream_out_TLAST
    );

endinterface

// File: rtl/noc_skid_buffer.sv
// 2-entry stream skid buffer with registered output and registered ready.
// Ports: clk/rst, in_* (upstream beat + ready), out_* (downstream beat).
module noc_skid_buffer
    import noc_stream_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last
);

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] keep;
        logic                last;
    } beat_t;

    beat_t       head_q, head_d;
    beat_t       tail_q, tail_d;
    beat_t       in_beat;
    logic [1:0]  count_q, count_d;
    logic        push, pop;

    // Ready comes straight from the occupancy flop: full only at 2.
    assign in_ready  = ~count_q[1];
    assign out_valid = |count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_beat   = '{data: in_data, keep: in_keep, last: in_last};

    assign out_data  = head_q.data;
    assign out_keep  = head_q.keep;
    assign out_last  = head_q.last;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_beat;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_beat;
                end else if (push) begin
                    tail_d  = in_beat;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // No push possible here: in_ready is low when full.
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC output stream.
// Ports: clk_line/clk_line_rst_high, bus (req_* in, stream_out_* out), busy, grant_id.
module noc_out_arbiter
    import noc_stream_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = NOC_DATA_W,
    parameter int ID_W   = noc_id_w(N_REQ)
) (
    input  logic              clk_line,
    input  logic              clk_line_rst_high,
    noc_out_arbiter_if.slave  bus,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    req_tready;
    logic                skid_in_valid;
    logic                skid_in_ready;

    logic                sel_valid;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W/8-1:0] sel_keep;
    logic                sel_last;

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] vld,
        input logic [ID_W-1:0]  ptr
    );
        logic [ID_W-1:0]  pick;
        logic             found;
        logic [N_REQ-1:0] rot;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            rot = vld >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // Granted requester's lane, selected by the held grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid = bus.req_TVALID[i];
                sel_data  = bus.req_TDATA[i*DATA_W +: DATA_W];
                sel_keep  = bus.req_TKEEP[i*(DATA_W/8) +: DATA_W/8];
                sel_last  = bus.req_TLAST[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        req_tready    = '0;
        skid_in_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_TVALID) begin
                    grant_id_d = rr_pick(bus.req_TVALID, rr_ptr_q);
                    busy_d     = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                req_tready    = N_REQ'(skid_in_ready) << grant_id_q;
                skid_in_valid = sel_valid;
                // Grant is released only by an accepted TLAST beat.
                if (sel_valid && skid_in_ready && sel_last) begin
                    rr_ptr_d = next_id(grant_id_q);
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    noc_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk_line),
        .rst       (clk_line_rst_high),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (sel_data),
        .in_keep   (sel_keep),
        .in_last   (sel_last),
        .out_valid (bus.stream_out_TVALID),
        .out_ready (bus.stream_out_TREADY),
        .out_data  (bus.stream_out_TDATA),
        .out_keep  (bus.stream_out_TKEEP),
        .out_last  (bus.stream_out_TLAST)
    );

    assign bus.req_TREADY = req_tready;
    assign busy           = busy_q;
    assign grant_id       = grant_id_q;

endmodule
